// File: rtl/ffss_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle ffss subtractor between NREQ requesters.
// Optional abort of a hung unit under FFSS_ARB_TIMEOUT_EN (sticky err).
module ffss_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 255,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              unit_start,
    output logic [W-1:0]      unit_a,
    output logic [W-1:0]      unit_b,
    input  logic [W-1:0]      unit_out,
    input  logic              unit_done,
    output logic              busy,
    output logic              err
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] ptr, grant, pick, ptr_nx;
    logic          any;
    logic          tmo;

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx  = 0;
        any  = 1'b0;
        pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req_valid[idx]) begin
                any  = 1'b1;
                pick = GW'(idx);
            end
        end
    end

    assign ptr_nx = (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);

`ifdef FFSS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;
    assign tmo = (tcnt == TW'(TIMEOUT - 1));
    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (unit_done || tmo) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            unit_a   <= '0;
            unit_b   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any) begin
                    grant  <= pick;
                    unit_a <= req_a[int'(pick)*W +: W];
                    unit_b <= req_b[int'(pick)*W +: W];
                end
                WAIT: begin
                    if (unit_done) rsp_data <= unit_out;
                    else if (tmo)  rsp_data <= '0;
                end
                RESP: ptr <= ptr_nx;
                default: ;
            endcase
        end
    end

`ifdef FFSS_ARB_TIMEOUT_EN
    // Counter is cleared in ISSUE so it reads 0 in the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + TW'(1);
            if (state == WAIT && !unit_done && tmo) err_q <= 1'b1;
        end
    end
`endif

    assign req_ready  = (state == IDLE && any) ? (NREQ'(1) << pick) : '0;
    assign rsp_valid  = (state == RESP) ? (NREQ'(1) << grant) : '0;
    assign unit_start = (state == ISSUE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ffss_arbiter.sv
// Directed bench for ffss_arbiter with a latency-5 (a-b) mod p stub and a result scoreboard.
module tb_ffss_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 255;
    localparam int LAT  = 5;
    localparam logic [255:0] P        = (256'd1 << 255) - 256'd19;
    localparam logic [255:0] WRAP_EXP = (256'd1 << 255) - 256'd26;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready, rsp_valid;
    logic [W-1:0]      rsp_data, unit_a, unit_b, unit_out;
    logic              unit_start, unit_done, busy, err;

    typedef struct {
        int           idx;
        logic [255:0] data;
    } exp_t;
    exp_t sb[$];

    int ntests = 0;
    int nfail  = 0;
    bit stub_hang = 1'b0;
    logic [255:0] opa [NREQ];
    logic [255:0] opb [NREQ];
    logic [255:0] res [NREQ];

    ffss_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_out(unit_out), .unit_done(unit_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // ffss stub: not tied to rst so a stale done can be observed after an abort.
    int          scnt = 0;
    logic [W-1:0] sres = '0;
    always @(posedge clk) begin
        if (unit_start) begin
            scnt <= LAT;
            if (unit_a >= unit_b) sres <= W'(256'(unit_a) - 256'(unit_b));
            else                  sres <= W'((256'(unit_a) + P) - 256'(unit_b));
        end else if (scnt != 0) begin
            scnt <= scnt - 1;
        end
    end
    assign unit_done = !stub_hang && (scnt == 1);
    assign unit_out  = sres;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            check("rsp_expected", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid_idx", 256'(rsp_valid), 256'(4'b0001 << e.idx));
                check("rsp_data", 256'(rsp_data), e.data);
            end
        end
    end

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(opa[i]);
            req_b[i*W +: W] = W'(opb[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One full transaction: accept at cycle 0, start at 1, rsp at 2+LAT.
    task automatic do_op(input logic [NREQ-1:0] mask, input int g, input bit hold);
        exp_t e;
        tick();
        req_valid = mask;
        @(negedge clk);
        check("req_ready", 256'(req_ready), 256'(4'b0001 << g));
        check("busy_idle", 256'(busy), 256'(0));
        e.idx  = g;
        e.data = res[g];
        sb.push_back(e);
        for (int c = 1; c <= 1 + LAT; c++) begin
            tick();
            if (!hold) req_valid = '0;
            @(negedge clk);
            check("unit_start", 256'(unit_start), 256'(c == 1));
            check("busy", 256'(busy), 256'(1));
            check("unit_a", 256'(unit_a), opa[g]);
            check("unit_b", 256'(unit_b), opb[g]);
            check("req_ready_busy", 256'(req_ready), 256'(0));
            check("rsp_early", 256'(rsp_valid), 256'(0));
        end
        tick();
        @(negedge clk);
        check("rsp_timing", 256'(rsp_valid), 256'(4'b0001 << g));
        check("busy_resp", 256'(busy), 256'(1));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; res[i] = '0; end
        tick(); tick();
        @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("rst_unit_start", 256'(unit_start), 256'(0));
        check("rst_rsp_data", 256'(rsp_data), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        tick();
        rst = 1'b0;

        // single request on requester 2
        opa[2] = 256'd10; opb[2] = 256'd3; res[2] = 256'd7; load_ops();
        do_op(4'b0100, 2, 1'b0);

        // modular wrap on requester 0
        opa[0] = 256'd3; opb[0] = 256'd10; res[0] = WRAP_EXP; load_ops();
        do_op(4'b0001, 0, 1'b0);

        // reset while in WAIT: no response, stale done ignored
        tick();
        req_valid = 4'b0100;
        @(negedge clk);
        check("rstw_accept", 256'(req_ready), 256'(4'b0100));
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_valid = '0;
            rst = (c == 4);
            @(negedge clk);
            if (c == 5) begin
                check("rstw_unit_a", 256'(unit_a), 256'(0));
                check("rstw_unit_b", 256'(unit_b), 256'(0));
                check("rstw_rsp_data", 256'(rsp_data), 256'(0));
                check("rstw_start", 256'(unit_start), 256'(0));
            end
            if (c >= 5) begin
                check("rstw_busy", 256'(busy), 256'(0));
                check("rstw_rsp_valid", 256'(rsp_valid), 256'(0));
            end
        end

        // contention: all held, grants 0,1,2,3,0 eight cycles apart
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 256'(100 + 10 * i); opb[i] = 256'(i); res[i] = 256'(100 + 9 * i);
        end
        load_ops();
        do_op(4'b1111, 0, 1'b1);
        do_op(4'b1111, 1, 1'b1);
        do_op(4'b1111, 2, 1'b1);
        do_op(4'b1111, 3, 1'b1);
        do_op(4'b1111, 0, 1'b1);

        // pointer wrap
        do_op(4'b1000, 3, 1'b1);
        do_op(4'b1001, 0, 1'b1);
        do_op(4'b1001, 3, 1'b1);

        // hung unit on requester 1
        stub_hang = 1'b1;
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        check("hang_accept", 256'(req_ready), 256'(4'b0010));
`ifdef FFSS_ARB_TIMEOUT_EN
        begin
            exp_t e;
            e.idx = 1; e.data = '0;
            sb.push_back(e);
        end
        for (int c = 1; c <= 76; c++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            if (c < 66) begin
                check("tmo_busy", 256'(busy), 256'(1));
                check("tmo_no_rsp", 256'(rsp_valid), 256'(0));
                check("tmo_err_low", 256'(err), 256'(0));
            end else if (c == 66) begin
                check("tmo_rsp", 256'(rsp_valid), 256'(4'b0010));
                check("tmo_err", 256'(err), 256'(1));
            end else begin
                check("tmo_err_sticky", 256'(err), 256'(1));
                check("tmo_idle", 256'(busy), 256'(0));
            end
        end
`else
        for (int c = 1; c <= 200; c++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            check("hang_busy", 256'(busy), 256'(1));
            check("hang_err", 256'(err), 256'(0));
            check("hang_no_rsp", 256'(rsp_valid), 256'(0));
        end
`endif
        tick();
        rst = 1'b1;
        stub_hang = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("final_err", 256'(err), 256'(0));
        check("final_busy", 256'(busy), 256'(0));
        check("sb_empty", 256'(sb.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/ffss_arbiter.md
Name: ffss_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle 255-bit field subtractor (ffss, start/done handshake) between NREQ requesters, e.g. point-add and point-double schedulers.
- Accepts one operand pair per grant, drives the unit's start pulse, waits for done, and returns the result one-hot to the granted requester.
- Sits between the ECC scalar-multiplication control FSMs and the shared ffss instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 255, field element width.
- TIMEOUT, 64, maximum WAIT cycles before abort; used only with FFSS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_a  in  NREQ*W  minuend; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  subtrahend; same slicing as req_a.
- req_ready  out  NREQ  one-hot 1-cycle accept pulse; operands are captured on that edge.
- rsp_valid  out  NREQ  one-hot 1-cycle result pulse to the granted requester.
- rsp_data  out  W  result; valid with rsp_valid, held until the next RESP.
- unit_start  out  1  1-cycle start pulse to ffss.
- unit_a  out  W  latched minuend, stable from ISSUE through WAIT.
- unit_b  out  W  latched subtrahend, stable from ISSUE through WAIT.
- unit_out  in  W  ffss result.
- unit_done  in  1  ffss completion.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; tied 0 without the macro.

Behaviour:
- Reset: state=IDLE, ptr=0, grant=0, all outputs 0. Reset mid-operation aborts with no rsp_valid. A later unit_done is ignored; ffss shares rst.
- IDLE: if any req_valid, grant the first set bit searching from ptr upward, wrapping modulo NREQ. req_ready[g] is combinational in this cycle. Latch req_a/req_b slice g and g itself, then go to ISSUE. No request: stay in IDLE.
- ISSUE: unit_start=1 for exactly one cycle, then go to WAIT. unit_done in ISSUE is ignored.
- WAIT: on unit_done=1, register unit_out into rsp_data and go to RESP. Otherwise hold.
- RESP: rsp_valid[g]=1 for one cycle; ptr <= (g+1) mod NREQ; go to IDLE.
- Timing: accept at cycle 0, start at cycle 1, done at cycle 1+L (L≥1 is the unit latency), rsp_valid at cycle 2+L. Next accept is possible at cycle 3+L.
- req_valid is sampled only in IDLE. Withdrawing it outside IDLE is legal and has no effect on an in-flight op.
- Fairness: with all requests held, each requester is served within NREQ grants.
- req_ready and rsp_valid are always zero or one-hot. Never more than one op is in flight.
- unit_done outside WAIT is ignored.
- The arbiter performs no arithmetic; rsp_data is passed through from unit_out.

Optional Feature:
FFSS_ARB_TIMEOUT_EN
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. If TIMEOUT WAIT cycles elapse without unit_done, go to RESP with rsp_data=0, set err=1 (sticky until rst), and advance ptr normally.
- Undefined: WAIT holds indefinitely, no counter logic, err tied 0.

Test Plan:
- Single request: stub ffss with L=5 computing (a-b) mod p, p=2^255-19. req_valid=4'b0100, slice2 a=10, b=3 -> req_ready[2] at cycle 0, unit_start at 1, rsp_valid[2] with rsp_data=7 at cycle 7, busy high cycles 1..7.
- Modular wrap through stub: a=3, b=10 on requester 0 -> rsp_data=2^255-26, rsp_valid=4'b0001.
- Contention: req_valid=4'b1111 held, distinct operands per requester -> grant order 0,1,2,3,0. Each rsp_valid index matches its grant and its own a-b. Accepts are 8 cycles apart with L=5.
- Pointer wrap: after a grant to 3, req_valid=4'b1001 -> next grant to 0; then with 4'b1001 still held -> grant to 3.
- Reset in WAIT: assert rst at cycle 4 of the single-request case -> next cycle all outputs 0, state IDLE. Stub done at cycle 6 ignored, no rsp_valid.
- Timeout (macro on, TIMEOUT=64, stub never done): rsp_valid[g] at cycle 66 with rsp_data=0 and err=1, err held until rst. Macro off: busy stays high for 200 cycles, err=0.
